// File: rtl/qei_input_filter.sv
// Quadrature encoder pin conditioner: per-channel synchroniser and stability filter,
// plus step/dir strobes and a sticky double-transition error.
module qei_input_filter #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic enc_a_raw,
    input  logic enc_b_raw,
    input  logic err_clr,
    output logic enc_a,
    output logic enc_b,
    output logic step,
    output logic dir,
    output logic err,
    output logic ready
);

    localparam int unsigned CW     = $clog2(FILTER_CYCLES + 1);
    localparam int unsigned SETTLE = SYNC_STAGES + FILTER_CYCLES;
    localparam int unsigned SW     = $clog2(SETTLE + 1);

    localparam logic [CW-1:0] CNT_LAST    = CW'(FILTER_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_a;
    logic [SYNC_STAGES-1:0] sync_b;
    logic [CW-1:0]          cnt_a;
    logic [CW-1:0]          cnt_b;
    logic [SW-1:0]          settle;

    logic s_a;
    logic s_b;
    logic acc_a;
    logic acc_b;
    logic fwd;

    assign s_a = sync_a[SYNC_STAGES-1];
    assign s_b = sync_b[SYNC_STAGES-1];

    // A channel flips once its synchronised level has disagreed for FILTER_CYCLES samples
    assign acc_a = (s_a != enc_a) && (cnt_a == CNT_LAST);
    assign acc_b = (s_b != enc_b) && (cnt_b == CNT_LAST);

    // Forward order 00->01->11->10: A moves forward when A==B, B moves forward when A!=B
    assign fwd = acc_a ? (enc_a == enc_b) : (enc_a != enc_b);

    // Synchroniser chains
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], enc_a_raw};
            sync_b <= {sync_b[SYNC_STAGES-2:0], enc_b_raw};
        end
    end

    // Stability counters and filtered levels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_a <= '0;
            cnt_b <= '0;
            enc_a <= 1'b0;
            enc_b <= 1'b0;
        end else begin
            cnt_a <= ((s_a == enc_a) || acc_a) ? '0 : cnt_a + CW'(1);
            cnt_b <= ((s_b == enc_b) || acc_b) ? '0 : cnt_b + CW'(1);
            enc_a <= enc_a ^ acc_a;
            enc_b <= enc_b ^ acc_b;
        end
    end

    // Settle / run FSM with registered strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= INIT;
            settle <= '0;
            step   <= 1'b0;
            dir    <= 1'b0;
            err    <= 1'b0;
            ready  <= 1'b0;
        end else begin
            step <= 1'b0;
            case (state)
                INIT: begin
                    if (acc_a || acc_b) begin
                        settle <= '0;
                    end else if (settle == SETTLE_LAST) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else begin
                        settle <= settle + SW'(1);
                    end
                end
                RUN: begin
                    if (acc_a ^ acc_b) begin
                        step <= 1'b1;
                        dir  <= fwd;
                    end
                    if (acc_a && acc_b) begin
                        err <= 1'b1;
                    end else if (err_clr) begin
                        err <= 1'b0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_qei_input_filter.sv
// Randomised bench for qei_input_filter: sliding-window reference model feeding a step scoreboard.
module tb_qei_input_filter;

    localparam int unsigned SYNC = 2;
    localparam int unsigned FILT = 16;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic enc_a_raw = 1'b0;
    logic enc_b_raw = 1'b0;
    logic err_clr   = 1'b0;
    logic enc_a, enc_b, step, dir, err, ready;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [1:0] pair;
        logic       dir;
    } ev_t;

    ev_t        exp_q[$];
    logic [1:0] hist[$];
    logic       m_a, m_b, m_run, m_err, m_step;
    int         m_quiet;
    logic       acc_a, acc_b, fwd;
    logic [1:0] old_p, new_p;

    always #5 clk = ~clk;

    qei_input_filter #(.SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT)) dut (
        .clk(clk), .rst(rst), .enc_a_raw(enc_a_raw), .enc_b_raw(enc_b_raw),
        .err_clr(err_clr), .enc_a(enc_a), .enc_b(enc_b), .step(step),
        .dir(dir), .err(err), .ready(ready)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int phase_idx(input logic [1:0] p);
        case (p)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        hist = {};
        for (int i = 0; i < int'(SYNC + FILT); i++) hist.push_back(2'b00);
        exp_q   = {};
        m_a     = 1'b0;
        m_b     = 1'b0;
        m_run   = 1'b0;
        m_err   = 1'b0;
        m_step  = 1'b0;
        m_quiet = 0;
    endtask

    // A level is accepted when the last FILT synchronised samples all disagree with it
    task automatic model_edge();
        hist.push_front({enc_b_raw, enc_a_raw});
        void'(hist.pop_back());
        acc_a = 1'b1;
        acc_b = 1'b1;
        for (int i = SYNC; i < int'(SYNC + FILT); i++) begin
            if (hist[i][0] == m_a) acc_a = 1'b0;
            if (hist[i][1] == m_b) acc_b = 1'b0;
        end
        old_p  = {m_b, m_a};
        new_p  = {m_b ^ acc_b, m_a ^ acc_a};
        fwd    = (phase_idx(new_p) == (phase_idx(old_p) + 1) % 4);
        m_step = 1'b0;
        if (m_run) begin
            if (acc_a != acc_b) begin
                m_step = 1'b1;
                exp_q.push_back('{pair: new_p, dir: fwd});
            end
            if (acc_a && acc_b) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end else begin
            if (acc_a || acc_b) m_quiet = 0;
            else m_quiet++;
            if (m_quiet == int'(SYNC + FILT)) m_run = 1'b1;
        end
        m_a = new_p[0];
        m_b = new_p[1];
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_edge();
        end
    end

    // Monitor: per-cycle level checks plus scoreboard pop on each step pulse
    initial begin
        ev_t ev;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("enc_pair", 8'({enc_b, enc_a}), 8'({m_b, m_a}));
                check("ready", 8'(ready), 8'(m_run));
                check("err", 8'(err), 8'(m_err));
                check("step", 8'(step), 8'(m_step));
                if (step) begin
                    if (exp_q.size() == 0) begin
                        check("step_unexpected", 8'(step), 8'(0));
                    end else begin
                        ev = exp_q.pop_front();
                        check("step_dir", 8'(dir), 8'(ev.dir));
                        check("step_pair", 8'({enc_b, enc_a}), 8'(ev.pair));
                    end
                end
            end
        end
    end

    task automatic hold(input logic [1:0] p, input int n);
        {enc_b_raw, enc_a_raw} = p;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int unsigned seg_p, seg_n;
        #3;
        check("reset_outputs", 8'({enc_a, enc_b, step, dir, err, ready}), 8'(0));
        @(negedge clk);
        rst = 1'b0;
        hold(2'b00, 30);
        // forward steps and return, then a reverse step from 00
        hold(2'b01, 30);
        hold(2'b11, 30);
        hold(2'b10, 30);
        hold(2'b00, 30);
        hold(2'b10, 30);
        hold(2'b00, 30);
        // glitch rejection at the acceptance boundary
        hold(2'b01, 15);
        hold(2'b00, 30);
        hold(2'b01, 16);
        hold(2'b00, 30);
        // bounce bursts before settling
        for (int i = 0; i < 8; i++) hold({1'b0, 1'(i % 2 == 0)}, 1);
        hold(2'b01, 30);
        for (int i = 0; i < 8; i++) hold({1'b0, 1'(i % 2 != 0)}, 1);
        hold(2'b00, 30);
        // illegal double jump, clear, then clear colliding with a new set
        hold(2'b11, 40);
        check("err_after_jump", 8'(err), 8'(1));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        hold(2'b11, 5);
        check("err_cleared", 8'(err), 8'(0));
        {enc_b_raw, enc_a_raw} = 2'b00;
        repeat (SYNC + FILT - 1) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_set_wins", 8'(err), 8'(1));
        hold(2'b00, 30);
        // randomised segments
        for (int s = 0; s < 60; s++) begin
            seg_p = $urandom_range(0, 3);
            seg_n = $urandom_range(1, 40);
            if ($urandom_range(0, 4) == 0) begin
                {enc_b_raw, enc_a_raw} = 2'(seg_p);
                err_clr = 1'b1;
                @(negedge clk);
                err_clr = 1'b0;
            end
            hold(2'(seg_p), int'(seg_n));
        end
        hold(2'b00, 40);
        // reset while the A filter is mid-count
        {enc_b_raw, enc_a_raw} = 2'b01;
        repeat (12) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("midop_reset", 8'({enc_a, enc_b, step, dir, err, ready}), 8'(0));
        @(negedge clk);
        rst = 1'b0;
        hold(2'b01, 60);
        check("post_reset_pair", 8'({enc_b, enc_a}), 8'(2'b01));
        check("post_reset_ready", 8'(ready), 8'(1));
        check("queue_empty", 8'(exp_q.size()), 8'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/qei_input_filter.md
# qei_input_filter

Front-end conditioner for the quadrature encoder pins. Raw A/B pins are asynchronous and may bounce, so this block synchronises them into the system clock and debounces each channel with a stability counter. It emits glitch-free `enc_a`/`enc_b` for the downstream quadrature counter, plus a per-transition `step`/`dir` strobe and a sticky error flag for illegal double transitions.

## Interface
- `SYNC_STAGES`, default 2: synchroniser depth per channel; must be ≥ 2.
- `FILTER_CYCLES`, default 16: consecutive cycles a synchronised level must differ from the filtered level before it is accepted; must be ≥ 1.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enc_a_raw`  in  1  raw encoder channel A pin, asynchronous.
- `enc_b_raw`  in  1  raw encoder channel B pin, asynchronous.
- `err_clr`  in  1  synchronous clear of `err`.
- `enc_a`  out  1  filtered channel A (registered).
- `enc_b`  out  1  filtered channel B (registered).
- `step`  out  1  one-cycle pulse per accepted single-channel transition (RUN only).
- `dir`  out  1  direction of last step: 1 = forward, 0 = reverse; valid while `step` = 1, holds otherwise.
- `err`  out  1  sticky: both channels accepted a change on the same edge (RUN only).
- `ready`  out  1  high once the initial settle is complete (RUN state).

## Operation
- **Synchroniser:** per channel, a chain of `SYNC_STAGES` flops produces the synchronised levels `s_a` and `s_b`. The chain resets to 0.
- **Filter:** per channel, a counter with width `$clog2(FILTER_CYCLES+1)`.
  - While `s` equals the filtered output, the counter is held at 0.
  - While `s` differs from the filtered output, the counter increments each edge.
  - On the edge where `s` differs and the counter equals `FILTER_CYCLES-1`, the filtered output takes the value of `s` and the counter returns to 0.
  - A mismatch that ends early returns the counter to 0 with no output change.
- **Phase order:** `{enc_b,enc_a}` = 00 → 01 → 11 → 10 → 00 is forward. The reverse order is reverse.
- **FSM states:** INIT and RUN. Reset enters INIT.
- **INIT:**
  - Filters run normally, but accepted changes never raise `step` or `err`.
  - A settle counter increments every edge and resets to 0 on any accepted change.
  - When the settle counter reaches `SYNC_STAGES+FILTER_CYCLES`, the FSM moves to RUN and `ready` becomes 1.
- **RUN:** stays in RUN until reset.
  - Exactly one channel accepts a change on an edge: `step` = 1 for the next cycle. `dir` = 1 if the new pair is the forward successor of the old pair, otherwise 0.
  - Both channels accept on the same edge: both outputs update, `step` stays 0, `dir` holds, `err` becomes 1.
- **err:** sticky. Cleared by `err_clr` = 1 on an edge. If a set condition and `err_clr` occur on the same edge, the set wins and `err` stays 1.
- **Reset, including mid-operation:** immediately clears every flop regardless of `clk`. Outputs go to `enc_a`=0, `enc_b`=0, `step`=0, `dir`=0, `err`=0, `ready`=0. The FSM returns to INIT.

## Timing
- **Latency:** a raw level change that is stable before rising edge 0 appears on the filtered output after edge `SYNC_STAGES+FILTER_CYCLES-1`. With defaults, `enc_a`/`enc_b` change on edge 17.
- **Strobes:** `step`/`dir`/`err` update on the same edge as the filtered output. `step` is never high for two consecutive cycles from the same transition.
- **Minimum accepted pulse:** a raw pulse must persist through `FILTER_CYCLES` synchronised samples to be accepted. Shorter pulses are fully rejected.
- **ready:** with inputs stable and matching reset levels, `ready` rises on rising edge `SYNC_STAGES+FILTER_CYCLES` after reset deassertion (edge 18 with defaults).
- **Reset release:** when deassertion is near a clock edge, the first edge may or may not count. Benches allow ±1 cycle here only.
- **Independence:** the two channel filters are independent. Acceptance edges one cycle apart are two legal steps, not an error.

## Test plan
- **Clean start:** reset, then release with raw = 00 held → `ready` rises on edge 18, outputs 00, `step`/`err` never assert.
- **Forward step:** after ready, raw A 0→1 held → `enc_a` = 1 on edge 17 after the change, `step` pulses for one cycle with `dir` = 1. Then raw B 0→1 → another step with `dir` = 1 (01 → 11).
- **Reverse step:** from 00 in RUN, raw B 0→1 held → `enc_b` = 1, `step` = 1, `dir` = 0.
- **Glitch rejection:** raw A high for 15 cycles then low → no output change and no step. A 16-cycle pulse → accepted and step issued. Separately, 8-cycle bounce bursts before a stable level → exactly one step.
- **Illegal jump:**
  - Raw 00 → 11 on the same cycle → both outputs go to 1 on the same edge, no step, `err` = 1 and it stays 1.
  - `err_clr` pulse → `err` = 0.
  - `err_clr` on the same edge as a new double jump → `err` stays 1.
- **Reset mid-operation:** assert `rst` while the A filter counter is at 10 in RUN → all outputs 0 with no clock edge, `ready` = 0. After release with raw = 01, outputs reach 01 without a step or error, then `ready` rises 18 edges after that acceptance.
